// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S playback transmitter.
// Slot geometry, FSM encoding and AXIS slot offsets.
package i2s_pkg;

  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 2 * SLOT_W;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int slot_off(
    input int   lane,
    input logic right,
    input int   slot_w
  );
    return (2 * lane + (right ? 1 : 0)) * slot_w;
  endfunction

endpackage

// File: rtl/i2s_tx_lane.sv
// One I2S data lane: a {left,right} shift register.
// The serial output is the register MSB.
module i2s_tx_lane
  import i2s_pkg::*;
#(
  parameter int W = FRAME_BITS
) (
  input  logic         sck,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  input  logic [W-1:0] data,
  output logic         sd
);

  logic [W-1:0] sr;

  always_ff @(posedge sck or posedge rst) begin
    if (rst)
      sr <= '0;
    else if (clear)
      sr <= '0;
    else if (load)
      sr <= data;
    else if (shift)
      sr <= {sr[W-2:0], 1'b0};
  end

  assign sd = sr[W-1];

endmodule

// File: rtl/i2s_dac_tx.sv
// AXI-Stream to multi-lane I2S transmitter, word-select master.
// One-beat holding buffer feeds per-lane frame shift registers.
module i2s_dac_tx #(
  parameter int  SLOT_W    = i2s_pkg::SLOT_W,
  parameter int  NUM_LANES = 2,
  localparam int DATA_W    = 2 * SLOT_W * NUM_LANES
) (
  input  logic                 sck,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    S_AXIS_tdata,
  input  logic                 S_AXIS_tvalid,
  input  logic                 S_AXIS_tlast,
  output logic                 S_AXIS_tready,
  output logic                 ws,
  output logic [NUM_LANES-1:0] sd,
  output logic                 block_end,
  output logic                 underrun
);

  import i2s_pkg::*;

  localparam int FB = 2 * SLOT_W;
  localparam int CW = $clog2(FB);
  localparam logic [CW-1:0] CNT_MAX = CW'(FB - 1);
  localparam logic [CW-1:0] WS_LO   = CW'(SLOT_W - 1);
  localparam logic [CW-1:0] WS_HI   = CW'(FB - 2);

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] buf_data;
  logic buf_valid;
  logic buf_last;
  logic frame_last;
  logic accept;
  logic load, shift, clear, urun;

  assign S_AXIS_tready = !buf_valid;
  assign accept = S_AXIS_tvalid && !buf_valid;

  always_ff @(posedge sck or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    shift    = 1'b0;
    clear    = 1'b0;
    urun     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start && buf_valid) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt != CNT_MAX) begin
          cnt_nx = cnt + 1'b1;
          shift  = 1'b1;
        end else begin
          cnt_nx = '0;
          if (!start) begin
            state_nx = IDLE;
            clear    = 1'b1;
          end else if (buf_valid) begin
            load = 1'b1;
          end else begin
            clear = 1'b1;
            urun  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ws is computed from the next count so it leads the slot MSB by one sck
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      ws         <= 1'b0;
      block_end  <= 1'b0;
      underrun   <= 1'b0;
      frame_last <= 1'b0;
      buf_valid  <= 1'b0;
      buf_last   <= 1'b0;
      buf_data   <= '0;
    end else begin
      cnt       <= cnt_nx;
      ws        <= (state_nx == RUN) && (cnt_nx >= WS_LO) &&
                   (cnt_nx <= WS_HI);
      block_end <= (state == RUN) && (cnt == CNT_MAX) && frame_last;
      if (urun)
        underrun <= 1'b1;
      if (load)
        frame_last <= buf_last;
      else if (clear)
        frame_last <= 1'b0;
      if (accept) begin
        buf_valid <= 1'b1;
        buf_data  <= S_AXIS_tdata;
        buf_last  <= S_AXIS_tlast;
      end else if (load) begin
        buf_valid <= 1'b0;
      end
    end
  end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    localparam int LO = slot_off(n, 1'b0, SLOT_W);
    localparam int RO = slot_off(n, 1'b1, SLOT_W);

    i2s_tx_lane #(
      .W(FB)
    ) u_lane (
      .sck  (sck),
      .rst  (rst),
      .load (load),
      .shift(shift),
      .clear(clear),
      .data ({buf_data[LO +: SLOT_W], buf_data[RO +: SLOT_W]}),
      .sd   (sd[n])
    );
  end

endmodule
